mmm_redc_90b: RTL and testbench

Word-serial Montgomery reduction (REDC) engine for the 90-bit NLP datapath. It consumes the 181-bit double-width product from the 90-bit multiplier and returns a fully reduced 90-bit residue, `T * R^-1 mod N` with `R = 2^96`. It sits directly downstream of the multiplier in the modular-multiply chain. Inputs arrive on a valid/ready handshake and results leave on one.

---
 rtl/mmm_nlp_pkg.sv | 22 ++
 rtl/mmm_redc_step.sv | 23 ++
 rtl/mmm_redc_90b.sv | 116 +++++++++++
 tb/tb_mmm_redc_90b.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_nlp_pkg.sv
// Shared constants and FSM encoding for the 90-bit NLP modular-multiply chain.
// Used by both the multiplier side and the REDC engine.
package mmm_nlp_pkg;

  localparam int TW     = 181;
  localparam int NW     = 90;
  localparam int WW     = 16;
  localparam int NWORDS = 6;

  // Working T register carries one guard bit above the input product.
  localparam int XW = TW + 1;
  localparam int CW = 3;
  localparam logic [CW-1:0] CNT_LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } redc_state_e;

endpackage

// File: rtl/mmm_redc_step.sv
// One combinational Montgomery REDC word step: T' = (T + m*N) >> WW,
// with m = T[WW-1:0] * n' mod 2^WW. Shared with the unrolled variant.
module mmm_redc_step
  import mmm_nlp_pkg::*;
(
  input  logic [XW-1:0] t,
  input  logic [NW-1:0] n,
  input  logic [WW-1:0] nprime,
  output logic [XW-1:0] t_next
);

  logic [WW-1:0]    m_s;
  logic [NW+WW-1:0] mn_s;
  logic [XW:0]      sum_s;

  assign m_s  = t[WW-1:0] * nprime;
  assign mn_s = {{NW{1'b0}}, m_s} * {{WW{1'b0}}, n};

  // Full-width add; the low WW bits are zero by choice of m, so the shift is exact.
  assign sum_s  = {1'b0, t} + {{(XW + 1 - NW - WW){1'b0}}, mn_s};
  assign t_next = XW'(sum_s >> WW);

endmodule

// File: rtl/mmm_redc_90b.sv
// Word-serial Montgomery reduction engine: returns T * 2^-96 mod N, fully reduced,
// over valid/ready handshakes on both sides. One REDC word per cycle.
module mmm_redc_90b
  import mmm_nlp_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [TW-1:0] i_t,
  input  logic [NW-1:0] i_n,
  input  logic [WW-1:0] i_nprime,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [NW-1:0] o_res
);

  redc_state_e   state_r;
  redc_state_e   state_nxt_s;
  logic [XW-1:0] t_r;
  logic [NW-1:0] n_r;
  logic [WW-1:0] np_r;
  logic [CW-1:0] cnt_r;
  logic [XW-1:0] t_step_s;
  logic [NW:0]   t_low_s;
  logic          sub_ge_s;
  logic [NW-1:0] res_sub_s;

  mmm_redc_step u_step (
    .t      (t_r),
    .n      (n_r),
    .nprime (np_r),
    .t_next (t_step_s)
  );

  // After the last word T < 2N, so its low NW+1 bits hold the whole value.
  assign t_low_s = t_r[NW:0];

  // Final conditional subtraction.
  always_comb begin
    sub_ge_s  = (t_low_s >= {1'b0, n_r});
    res_sub_s = t_low_s[NW-1:0];
    if (sub_ge_s) begin
      res_sub_s = NW'(t_low_s - {1'b0, n_r});
    end else begin
      res_sub_s = t_low_s[NW-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) state_nxt_s = ST_ITER;
        else         state_nxt_s = ST_IDLE;
      end
      ST_ITER: begin
        if (cnt_r == CNT_LAST) state_nxt_s = ST_SUB;
        else                   state_nxt_s = ST_ITER;
      end
      ST_SUB:  state_nxt_s = ST_DONE;
      ST_DONE: begin
        if (i_ready) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      o_valid <= (state_nxt_s == ST_DONE);
      o_ready <= (state_nxt_s == ST_IDLE);
    end
  end

  // Datapath: capture on accept, one word step per ITER cycle, result in SUB.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      t_r   <= '0;
      n_r   <= '0;
      np_r  <= '0;
      cnt_r <= '0;
      o_res <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            t_r   <= {1'b0, i_t};
            n_r   <= i_n;
            np_r  <= i_nprime;
            cnt_r <= '0;
          end
        end
        ST_ITER: begin
          t_r   <= t_step_s;
          cnt_r <= cnt_r + 3'd1;
        end
        ST_SUB:  o_res <= res_sub_s;
        default: o_res <= o_res;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_redc_90b.sv
// Self-checking bench for mmm_redc_90b: vector table, scoreboard queue and
// hand-written backpressure / mid-operation reset sequences.
module tb_mmm_redc_90b;
  import mmm_nlp_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b1;
  logic [TW-1:0] i_t = '0;
  logic [NW-1:0] i_n = '0;
  logic [WW-1:0] i_np = '0;
  logic          o_ready;
  logic          o_valid;
  logic [NW-1:0] o_res;

  int total = 0;
  int bad = 0;
  logic [NW-1:0] sb_q[$];

  typedef struct {
    logic [TW-1:0] t;
    logic [NW-1:0] n;
    logic [WW-1:0] np;
    logic [NW-1:0] exp;
  } vec_t;
  vec_t vecs[14];

  mmm_redc_90b dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_t      (i_t),
    .i_n      (i_n),
    .i_nprime (i_np),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_res    (o_res)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bitwise halving mod N, 96 times, then one final reduction.
  function automatic logic [NW-1:0] redc_ref(input logic [TW-1:0] t, input logic [NW-1:0] n);
    logic [TW+1:0] x;
    logic [TW+1:0] nx;
    x  = {2'b00, t};
    nx = {{(TW + 2 - NW){1'b0}}, n};
    for (int i = 0; i < 96; i++) begin
      if (x[0]) x = x + nx;
      x = x >> 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (x >= nx) x = x - nx;
    end
    return x[NW-1:0];
  endfunction

  function automatic logic [WW-1:0] nprime_of(input logic [NW-1:0] n);
    logic [WW-1:0] n0;
    logic [WW-1:0] inv;
    n0  = n[WW-1:0];
    inv = n0;
    for (int i = 0; i < 4; i++) inv = inv * (16'd2 - n0 * inv);
    return 16'd0 - inv;
  endfunction

  function automatic logic [TW-1:0] rand_wide();
    logic [TW-1:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = {r[TW-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic send(input vec_t v);
    int w;
    w = 0;
    while (!o_ready && w < 20) begin
      tick();
      w++;
    end
    check("ready_before_send", XW'(o_ready), XW'(1'b1));
    i_valid = 1'b1;
    i_t     = v.t;
    i_n     = v.n;
    i_np    = v.np;
    tick();
    sb_q.push_back(v.exp);
    i_valid = 1'b0;
    i_t     = rand_wide();
    i_n     = NW'(rand_wide());
    i_np    = 16'($urandom);
  endtask

  // Waits for o_valid, pulsing i_valid meanwhile; checks latency and o_ready low.
  task automatic wait_out(input string name);
    int lat;
    int rdy_hi;
    lat    = 0;
    rdy_hi = 0;
    while (!o_valid && lat < 20) begin
      if (o_ready) rdy_hi++;
      i_valid = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    i_valid = 1'b0;
    check({name, "_latency"}, XW'(lat), XW'(7));
    check({name, "_busy_ready"}, XW'(rdy_hi), XW'(0));
  endtask

  task automatic take(input string name);
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, XW'(1'b1), XW'(1'b0));
    end else begin
      check({name, "_res"}, XW'(o_res), XW'(sb_q.pop_front()));
    end
    i_ready = 1'b1;
    tick();
    check({name, "_handoff_valid"}, XW'(o_valid), XW'(1'b0));
    check({name, "_handoff_ready"}, XW'(o_ready), XW'(1'b1));
  endtask

  initial begin
    logic [NW-1:0] n89;
    logic [NW-1:0] nmax;
    logic [TW-1:0] tall;
    logic [NW-1:0] hold;
    vec_t v;

    n89  = (NW'(1) << 89) + NW'(1);
    nmax = '1;
    tall = '1;
    vecs[0] = '{t: '0,                n: NW'(3), np: 16'h5555, exp: NW'(0)};
    vecs[1] = '{t: TW'(1) << 97,      n: NW'(3), np: 16'h5555, exp: NW'(2)};
    vecs[2] = '{t: TW'(1) << 180,     n: n89,    np: 16'hFFFF, exp: NW'(1) << 84};
    vecs[3] = '{t: tall,              n: n89,    np: 16'hFFFF, exp: redc_ref(tall, n89)};
    vecs[4] = '{t: tall,              n: nmax,   np: nprime_of(nmax), exp: redc_ref(tall, nmax)};
    vecs[5] = '{t: (TW'(3) << 96) - TW'(1), n: NW'(3), np: 16'h5555,
                exp: redc_ref((TW'(3) << 96) - TW'(1), NW'(3))};
    vecs[6] = '{t: TW'(5) << 96,      n: NW'(7), np: nprime_of(NW'(7)), exp: NW'(5)};
    for (int i = 7; i < 14; i++) begin
      v.n = NW'(rand_wide());
      v.n[0] = 1'b1;
      v.n[NW-1] = 1'b1;
      v.t = rand_wide();
      v.np = nprime_of(v.n);
      v.exp = redc_ref(v.t, v.n);
      vecs[i] = v;
    end

    // Reset state
    #23;
    check("rst_valid", XW'(o_valid), XW'(1'b0));
    check("rst_res", XW'(o_res), XW'(0));
    rstn = 1'b1;
    tick();
    check("post_rst_ready", XW'(o_ready), XW'(1'b1));
    check("post_rst_valid", XW'(o_valid), XW'(1'b0));

    for (int i = 0; i < 14; i++) begin
      send(vecs[i]);
      wait_out($sformatf("vec%0d", i));
      check($sformatf("vec%0d_lt_n", i), XW'(o_res < vecs[i].n), XW'(1'b1));
      take($sformatf("vec%0d", i));
    end

    // Backpressure: hold i_ready low in DONE, pulse i_valid
    send(vecs[2]);
    i_ready = 1'b0;
    wait_out("bp");
    hold = o_res;
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1;
      tick();
      check($sformatf("bp_stable%0d", c), XW'(o_res), XW'(hold));
      check($sformatf("bp_ready%0d", c), XW'(o_ready), XW'(1'b0));
      check($sformatf("bp_valid%0d", c), XW'(o_valid), XW'(1'b1));
    end
    i_valid = 1'b0;
    take("bp");

    // Reset mid-ITER: o_res currently holds a nonzero result
    send(vecs[3]);
    tick();
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_valid", XW'(o_valid), XW'(1'b0));
    check("midrst_res", XW'(o_res), XW'(0));
    sb_q.delete();
    #3;
    rstn = 1'b1;
    tick();
    check("midrst_ready", XW'(o_ready), XW'(1'b1));
    check("midrst_novalid", XW'(o_valid), XW'(1'b0));
    send(vecs[1]);
    wait_out("after_rst");
    take("after_rst");

    check("sb_drained", XW'(sb_q.size()), XW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
